// File: rtl/mem_ctrl_pkg.sv
// Shared types and widths for the memory command arbiter.
//   mem_cmd_t   : 2-bit command encoding seen by requesters and the memory controller
//   arb_state_t : arbiter FSM states
//   ADDR_W      : address width
//   DATA_W      : data width
package mem_ctrl_pkg;

  localparam int ADDR_W = 64;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    NOP   = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b10,
    CLEAR = 2'b11
  } mem_cmd_t;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_ACK,
    WAIT_DONE,
    RESP
  } arb_state_t;

endpackage

// File: rtl/mem_cmd_arbiter_rr_arb2.sv
// Two-way round-robin pick, purely combinational.
//   req[1:0]  in  : request levels of requester 0 and 1
//   lastGrant in  : index of the requester served most recently
//   valid     out : at least one request present
//   winner    out : index of the chosen requester (meaningful when valid)
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       lastGrant,
  output logic       valid,
  output logic       winner
);

  always_comb begin
    valid = |req;
    // On contention the requester that was not served last goes first;
    // otherwise the only active requester wins.
    if (req == 2'b11) begin
      winner = ~lastGrant;
    end else begin
      winner = req[1];
    end
  end

endmodule

// File: rtl/mem_cmd_arbiter.sv
// Arbitrates two command requesters onto a single memory controller port.
//   clk, rst                          : clock, asynchronous active-high reset
//   rN_req/rN_cmd/rN_addr/rN_wdata    : requester N command (req held until rN_done)
//   rN_done/rN_err                    : one-cycle completion pulse / timeout flag
//   rd_data                           : result of the last successful READ
//   mem_cmd/mem_addr/mem_wdata        : command to memory controller
//   mem_start                         : command-valid strobe, held until mem_done drops
//   mem_done/mem_rdata                : memory idle/done level and read data
//   grant                             : index of current owner
//   busy                              : FSM not in IDLE
module mem_cmd_arbiter
  import mem_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_req,
  input  logic [1:0]        r0_cmd,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_done,
  output logic              r0_err,
  input  logic              r1_req,
  input  logic [1:0]        r1_cmd,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_done,
  output logic              r1_err,
  output logic [DATA_W-1:0] rd_data,
  output logic [1:0]        mem_cmd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_start,
  input  logic              mem_done,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              grant,
  output logic              busy
);

  arb_state_t        state;
  arb_state_t        nextState;
  mem_cmd_t          curCmd;
  mem_cmd_t          pickCmd;
  logic [ADDR_W-1:0] curAddr;
  logic [DATA_W-1:0] curWdata;
  logic              lastGrant;
  logic [7:0]        waitCount;
  logic              waitExpired;
  logic              timedOut;
  logic              pickValid;
  logic              pickWinner;
  logic              accept;

  rr_arb2 u_rrArb (
    .req       ({r1_req, r0_req}),
    .lastGrant (lastGrant),
    .valid     (pickValid),
    .winner    (pickWinner)
  );

  assign pickCmd     = mem_cmd_t'(pickWinner ? r1_cmd : r0_cmd);
  // A new command is only taken while the memory reports idle.
  assign accept      = (state == IDLE) && pickValid && mem_done;
  // >= rather than == so a count that passes the limit still aborts.
  assign waitExpired = (waitCount >= 8'(TIMEOUT_CYCLES - 1));
  assign mem_addr    = curAddr;
  assign mem_wdata   = curWdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    mem_start = 1'b0;
    mem_cmd   = NOP;
    busy      = (state != IDLE);
    r0_done   = 1'b0;
    r0_err    = 1'b0;
    r1_done   = 1'b0;
    r1_err    = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          // NOP completes without touching memory.
          nextState = (pickCmd == NOP) ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        mem_start = 1'b1;
        mem_cmd   = curCmd;
        nextState = WAIT_ACK;
      end
      WAIT_ACK: begin
        mem_start = 1'b1;
        mem_cmd   = curCmd;
        if (!mem_done) begin
          nextState = WAIT_DONE;
        end else if (waitExpired) begin
          nextState = RESP;
        end
      end
      WAIT_DONE: begin
        mem_cmd = curCmd;
        if (mem_done || waitExpired) begin
          nextState = RESP;
        end
      end
      RESP: begin
        r0_done   = ~grant;
        r1_done   = grant;
        r0_err    = ~grant & timedOut;
        r1_err    = grant & timedOut;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      curCmd    <= NOP;
      curAddr   <= '0;
      curWdata  <= '0;
      grant     <= 1'b0;
      lastGrant <= 1'b1;
      rd_data   <= '0;
      waitCount <= '0;
      timedOut  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            grant     <= pickWinner;
            curCmd    <= pickCmd;
            curAddr   <= pickWinner ? r1_addr : r0_addr;
            curWdata  <= pickWinner ? r1_wdata : r0_wdata;
            waitCount <= '0;
            timedOut  <= 1'b0;
          end
        end
        WAIT_ACK: begin
          waitCount <= waitCount + 8'd1;
          if (mem_done && waitExpired) begin
            timedOut <= 1'b1;
          end
        end
        WAIT_DONE: begin
          waitCount <= waitCount + 8'd1;
          if (mem_done) begin
            if (curCmd == READ) begin
              rd_data <= mem_rdata;
            end
          end else if (waitExpired) begin
            timedOut <= 1'b1;
          end
        end
        RESP: begin
          lastGrant <= grant;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_cmd_arbiter.sv
module tb_mem_cmd_arbiter;
  import mem_ctrl_pkg::*;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        r0_req, r1_req;
  logic [1:0]  r0_cmd, r1_cmd;
  logic [63:0] r0_addr, r1_addr;
  logic [31:0] r0_wdata, r1_wdata;
  logic        r0_done, r0_err, r1_done, r1_err;
  logic [31:0] rd_data;
  logic [1:0]  mem_cmd;
  logic [63:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_start;
  logic        mem_done;
  logic [31:0] mem_rdata;
  logic        grant, busy;

  mem_cmd_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .r0_req(r0_req), .r0_cmd(r0_cmd), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_done(r0_done), .r0_err(r0_err),
    .r1_req(r1_req), .r1_cmd(r1_cmd), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_done(r1_done), .r1_err(r1_err),
    .rd_data(rd_data), .mem_cmd(mem_cmd), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_start(mem_start), .mem_done(mem_done), .mem_rdata(mem_rdata),
    .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        who;
    logic        err;
    logic [31:0] rd;
    int          starts;
    int          busyCyc;
    logic [1:0]  cmd;
    logic [63:0] addr;
    logic [31:0] wdata;
  } exp_t;

  exp_t        sb[$];
  int          compared = 0;
  int          mismatched = 0;
  int          rem0 = 0, rem1 = 0;
  int          memDelay = 3;
  bit          memHang = 0;
  int          txn = 0;
  logic [31:0] rdataQ[$];

  function automatic exp_t mk(input logic who, input logic err, input logic [31:0] rd,
                              input int starts, input int busyCyc, input logic [1:0] cmd,
                              input logic [63:0] addr, input logic [31:0] wdata);
    exp_t e;
    e.who = who; e.err = err; e.rd = rd; e.starts = starts; e.busyCyc = busyCyc;
    e.cmd = cmd; e.addr = addr; e.wdata = wdata;
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    check({tag, "_ctrl_outputs"},
          {56'd0, r0_done, r0_err, r1_done, r1_err, mem_start, grant, busy, mem_cmd != 2'b00}, 64'd0);
    check({tag, "_rd_data"}, {32'd0, rd_data}, 64'd0);
    check({tag, "_mem_addr"}, mem_addr, 64'd0);
    check({tag, "_mem_wdata"}, {32'd0, mem_wdata}, 64'd0);
  endtask

  // Memory controller model: drops mem_done one edge after seeing mem_start,
  // raises it again memDelay edges later (or only after the arbiter gives up).
  initial begin
    mem_done  = 1'b1;
    mem_rdata = 32'h0;
    forever begin
      @(posedge clk);
      if (mem_start === 1'b1 && mem_done) begin
        #1 mem_done = 1'b0;
        if (memHang) begin
          wait (r0_done || r1_done);
          @(posedge clk);
          #1 mem_done = 1'b1;
        end else begin
          repeat (memDelay) @(posedge clk);
          #1;
          mem_rdata = (rdataQ.size() > 0) ? rdataQ.pop_front() : (32'hBAD0_0000 + 32'(txn));
          txn++;
          mem_done = 1'b1;
        end
      end
    end
  end

  // Requesters release req once their remaining transaction count is used up.
  always @(negedge clk) begin
    if (r0_done && rem0 > 0) begin
      rem0--;
      if (rem0 == 0) r0_req = 1'b0;
    end
    if (r1_done && rem1 > 0) begin
      rem1--;
      if (rem1 == 0) r1_req = 1'b0;
    end
  end

  // Monitor: per-cycle command checks and one scoreboard pop per done pulse.
  int   startCnt = 0;
  int   busyCnt = 0;
  logic prevDone = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      startCnt = 0;
      busyCnt  = 0;
      prevDone = 1'b0;
    end else begin
      if (mem_start) startCnt++;
      if (busy && !r0_done && !r1_done) begin
        busyCnt++;
        if (sb.size() > 0) begin
          check("mem_cmd_held", {62'd0, mem_cmd}, {62'd0, sb[0].cmd});
          check("mem_addr_held", mem_addr, sb[0].addr);
          check("mem_wdata_held", {32'd0, mem_wdata}, {32'd0, sb[0].wdata});
        end
      end else begin
        check("mem_cmd_idle", {62'd0, mem_cmd}, 64'd0);
      end
      if (r0_done || r1_done) begin
        check("done_single_cycle", {63'd0, prevDone}, 64'd0);
        check("done_both", {63'd0, r0_done && r1_done}, 64'd0);
        if (sb.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_done: got r0_done=%0b r1_done=%0b expected none", r0_done, r1_done);
        end else begin
          e = sb.pop_front();
          check("done_requester", {63'd0, r1_done}, {63'd0, e.who});
          check("err_flag", {63'd0, r1_done ? r1_err : r0_err}, {63'd0, e.err});
          check("err_other", {63'd0, r1_done ? r0_err : r1_err}, 64'd0);
          check("grant", {63'd0, grant}, {63'd0, e.who});
          check("rd_data", {32'd0, rd_data}, {32'd0, e.rd});
          check("mem_start_cycles", 64'(startCnt), 64'(e.starts));
          check("busy_cycles", 64'(busyCnt), 64'(e.busyCyc));
          $display("txn: requester %0d cmd %0d err %0b rd_data %08h starts %0d busy %0d",
                   r1_done, e.cmd, r1_done ? r1_err : r0_err, rd_data, startCnt, busyCnt);
        end
        startCnt = 0;
        busyCnt  = 0;
      end
      prevDone = r0_done | r1_done;
    end
  end

  task automatic waitIdle(input string name);
    int n = 0;
    while ((r0_req || r1_req || busy || !mem_done) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({name, "_completed_in_time"}, {63'd0, n >= 300}, 64'd0);
    check({name, "_scoreboard_drained"}, 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    sb.delete();
    r0_req = 1'b0; r1_req = 1'b0; rem0 = 0; rem1 = 0;
    #1 checkResetOutputs("reset");
    @(negedge clk);
    #2 rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1;
    r0_req = 1'b0; r1_req = 1'b0;
    r0_cmd = 2'b00; r1_cmd = 2'b00;
    r0_addr = '0; r1_addr = '0; r0_wdata = '0; r1_wdata = '0;
    repeat (3) @(negedge clk);
    checkResetOutputs("init");
    #2 rst = 1'b0;

    // Single WRITE from r0.
    @(negedge clk);
    sb.push_back(mk(1'b0, 1'b0, 32'h0, 2, 5, WRITE, 64'hFF, 32'hA5A5_A5A5));
    r0_cmd = WRITE; r0_addr = 64'hFF; r0_wdata = 32'hA5A5_A5A5; rem0 = 1; r0_req = 1'b1;
    waitIdle("write_r0");

    // Simultaneous READs after reset: r0 first, then r1.
    doReset();
    @(negedge clk);
    rdataQ.push_back(32'h1111);
    rdataQ.push_back(32'h2222);
    sb.push_back(mk(1'b0, 1'b0, 32'h1111, 2, 5, READ, 64'h100, 32'h0));
    sb.push_back(mk(1'b1, 1'b0, 32'h2222, 2, 5, READ, 64'h200, 32'h7));
    r0_cmd = READ; r0_addr = 64'h100; r0_wdata = 32'h0;
    r1_cmd = READ; r1_addr = 64'h200; r1_wdata = 32'h7;
    rem0 = 1; rem1 = 1; r0_req = 1'b1; r1_req = 1'b1;
    waitIdle("dual_read");

    // Both held for four transactions: grants 0,1,0,1.
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) sb.push_back(mk(1'b0, 1'b0, 32'h2222, 2, 5, WRITE, 64'h1000, 32'h10));
      else            sb.push_back(mk(1'b1, 1'b0, 32'h2222, 2, 5, WRITE, 64'h2000, 32'h20));
    end
    r0_cmd = WRITE; r0_addr = 64'h1000; r0_wdata = 32'h10;
    r1_cmd = WRITE; r1_addr = 64'h2000; r1_wdata = 32'h20;
    rem0 = 2; rem1 = 2; r0_req = 1'b1; r1_req = 1'b1;
    waitIdle("round_robin");

    // r1 CLEAR with a memory that never completes: timeout after 8 wait cycles.
    @(negedge clk);
    memHang = 1'b1;
    sb.push_back(mk(1'b1, 1'b1, 32'h2222, 2, 1 + TO, CLEAR, 64'hABC, 32'h0));
    r1_cmd = CLEAR; r1_addr = 64'hABC; r1_wdata = 32'h0; rem1 = 1; r1_req = 1'b1;
    waitIdle("timeout_clear");
    memHang = 1'b0;

    // r0 NOP: completes without touching memory.
    @(negedge clk);
    sb.push_back(mk(1'b0, 1'b0, 32'h2222, 0, 0, NOP, 64'h5, 32'h0));
    r0_cmd = NOP; r0_addr = 64'h5; r0_wdata = 32'h0; rem0 = 1; r0_req = 1'b1;
    waitIdle("nop");

    // r0 READ aborted by reset while waiting for the memory.
    @(negedge clk);
    memDelay = 6;
    sb.push_back(mk(1'b0, 1'b0, 32'h0, 2, 0, READ, 64'h300, 32'h0));
    r0_cmd = READ; r0_addr = 64'h300; r0_wdata = 32'h0; rem0 = 1; r0_req = 1'b1;
    n = 0;
    while (!(busy && !mem_start) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("abort_reached_wait_done", {63'd0, n < 50}, 64'd1);
    #2 rst = 1'b1;
    sb.delete();
    r0_req = 1'b0; rem0 = 0; memDelay = 3;
    #1 checkResetOutputs("abort");
    @(negedge clk);
    #2 rst = 1'b0;
    // Memory is still busy: contention must wait, then r0 wins first.
    sb.push_back(mk(1'b0, 1'b0, 32'h0, 2, 5, WRITE, 64'h400, 32'h44));
    sb.push_back(mk(1'b1, 1'b0, 32'h0, 2, 5, WRITE, 64'h500, 32'h55));
    r0_cmd = WRITE; r0_addr = 64'h400; r0_wdata = 32'h44;
    r1_cmd = WRITE; r1_addr = 64'h500; r1_wdata = 32'h55;
    rem0 = 1; rem1 = 1; r0_req = 1'b1; r1_req = 1'b1;
    @(negedge clk);
    check("blocked_mem_done_low", {63'd0, mem_done}, 64'd0);
    check("blocked_busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    check("blocked_mem_start", {63'd0, mem_start}, 64'd0);
    waitIdle("post_abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mem_cmd_arbiter.md
MEM_CMD_ARBITER -- requirements
Module: mem_cmd_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 255, max cycles from mem_start to mem_done rise before abort (1..255).
REQ-002 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  in  1  reset, asynchronous, active-high.
REQ-004 Ports (N in {0,1}): rN_req  in  1  request valid, level, held until rN_done.
REQ-005 Ports: rN_cmd  in  2  00 NOP, 01 READ, 10 WRITE, 11 CLEAR.
REQ-006 Ports: rN_addr  in  64  target address; rN_wdata  in  32  write data.
REQ-007 Ports: rN_done  out  1  one-cycle completion pulse; rN_err  out  1  timeout flag, valid with rN_done.
REQ-008 Port: rd_data  out  32  last READ result, shared by both requesters.
REQ-009 Ports: mem_cmd  out  2; mem_addr  out  64; mem_wdata  out  32  command to memory controller.
REQ-010 Port: mem_start  out  1  command-valid strobe to memory controller.
REQ-011 Ports: mem_done  in  1  memory idle/done level; mem_rdata  in  32  read data.
REQ-012 Ports: grant  out  1  index of current owner; busy  out  1  high in any state except IDLE.

Function
REQ-013 FSM states SHALL be IDLE, ISSUE, WAIT_ACK, WAIT_DONE, RESP.
REQ-014 IDLE: when any rN_req=1 and mem_done=1, pick winner, register its cmd/addr/wdata, set grant, go ISSUE next cycle.
REQ-015 Arbitration: single requester wins; both requesting -> requester other than last_grant wins (round robin).
REQ-016 Winner with cmd NOP SHALL go IDLE->RESP directly, memory untouched, rN_err=0.
REQ-017 ISSUE: mem_start=1, mem_cmd/mem_addr/mem_wdata driven from registered values; go WAIT_ACK.
REQ-018 WAIT_ACK: hold mem_start=1 until mem_done=0, then WAIT_DONE with mem_start=0.
REQ-019 WAIT_DONE: on mem_done=1, capture mem_rdata into rd_data if cmd=READ; go RESP.
REQ-020 mem_cmd, mem_addr, mem_wdata SHALL be stable across ISSUE/WAIT_ACK/WAIT_DONE; mem_cmd=00 in IDLE and RESP.
REQ-021 Timeout counter SHALL clear on ISSUE entry, increment each WAIT_ACK/WAIT_DONE cycle; at TIMEOUT_CYCLES go RESP with err set.
REQ-022 RESP: pulse done (and err if timed out) of granted requester for exactly one cycle; update last_grant; go IDLE.
REQ-023 Latency: req sampled in IDLE at edge k -> mem_start high cycle k+1; done pulse one cycle after mem_done rise is sampled.
REQ-024 rN_req still high in the IDLE cycle after RESP SHALL be a new request, subject to REQ-015.
REQ-025 rd_data SHALL hold until the next successful READ; unchanged on WRITE, CLEAR, NOP, timeout.
REQ-026 Request arriving mid-transaction SHALL wait; requester inputs ignored outside IDLE.
REQ-027 mem_done=0 in IDLE SHALL block issuing (memory still busy).

Reset
REQ-028 rst=1 SHALL immediately force IDLE; all outputs 0, including rd_data and grant.
REQ-029 Reset SHALL set last_grant=1 so requester 0 wins the first contention.
REQ-030 Reset mid-transaction SHALL abort without a done pulse; the memory side sees mem_start and mem_cmd drop to 0.

Structure
REQ-031 Package mem_ctrl_pkg SHALL hold mem_cmd_t enum (NOP, READ, WRITE, CLEAR), arb_state_t, ADDR_W=64, DATA_W=32.
REQ-032 Sub-module rr_arb2 SHALL implement the 2-way round-robin pick (req[1:0], last_grant -> valid, winner), combinational.

Verification
REQ-033 r0 WRITE addr 0x0000_00FF data 0xA5A5_A5A5, memory drops and raises mem_done after 3 cycles -> mem_start for 2 cycles, mem_cmd=10 held, r0_done one pulse, r0_err=0.
REQ-034 r0 and r1 READ simultaneously after reset, mem_rdata 0x1111 then 0x2222 -> r0 served first, rd_data=0x1111 then 0x2222, r1_done follows r0_done.
REQ-035 r0 and r1 held high for 4 transactions -> grants alternate 0,1,0,1.
REQ-036 r1 CLEAR, mem_done never rises, TIMEOUT_CYCLES=8 -> r1_done and r1_err pulse after 8 wait cycles, rd_data unchanged.
REQ-037 r0 NOP -> r0_done two cycles after req, mem_start never asserted.
REQ-038 rst pulsed during WAIT_DONE -> all outputs 0 asynchronously, no done pulse, next contention granted to r0.
